// File: rtl/fc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fc_seq_pkg
// Brief   : Shared state encoding and address-width helper for the
//           fully-connected layer sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package fc_seq_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RUN     = 3'd1,
      BIAS    = 3'd2,
      CAPTURE = 3'd3,
      OUT     = 3'd4
   } fc_seq_state_t;

   // ROM spans addresses 0..height (weights plus one bias slot).
   function automatic int addr_width(input int height);
      return (height < 1) ? 1 : $clog2(height + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fc_seq_addr_pipe.sv
`default_nettype none
// ============================================================================
// Module  : fc_seq_addr_pipe
// Brief   : ROM address counter plus one-stage delayed input-word broadcast,
//           aligning each word with the ROM's one-cycle read latency.
// Revision: 1.0 - initial release
// ============================================================================
module fc_seq_addr_pipe
   import fc_seq_pkg::*;
#(
   parameter int WORD_SIZE             = 16,
   parameter int PREVIOUS_LAYER_HEIGHT = 4,
   parameter int ADDR_W                = addr_width(PREVIOUS_LAYER_HEIGHT)
)(
   input  logic                                       clk_i,
   input  logic                                       reset_i,
   input  logic                                       i_run,
   input  logic [PREVIOUS_LAYER_HEIGHT*WORD_SIZE-1:0] i_data,
   output logic [ADDR_W-1:0]                          o_cnt,
   output logic                                       o_cnt_last,
   output logic [WORD_SIZE-1:0]                       o_bcast_data,
   output logic                                       o_sum_en
);

   localparam logic [ADDR_W-1:0] c_last = ADDR_W'(PREVIOUS_LAYER_HEIGHT);

   logic [ADDR_W-1:0]    r_cnt;
   logic [WORD_SIZE-1:0] r_bcast;
   logic                 r_sum_en;
   logic                 w_last;
   logic                 w_issue;
   logic [WORD_SIZE-1:0] w_word;
   logic [WORD_SIZE-1:0] w_words [PREVIOUS_LAYER_HEIGHT];

   generate
      for (genvar g = 0; g < PREVIOUS_LAYER_HEIGHT; g++) begin : g_unpack
         assign w_words[g] = i_data[g*WORD_SIZE +: WORD_SIZE];
      end
   endgenerate

   assign w_last  = (r_cnt == c_last);
   // The bias address carries no input word, so it never raises sum_en.
   assign w_issue = i_run && !w_last;

   always_comb begin
      w_word = '0;
      for (int k = 0; k < PREVIOUS_LAYER_HEIGHT; k++) begin
         if (r_cnt == ADDR_W'(k)) begin
            w_word = w_words[k];
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_cnt    <= '0;
         r_sum_en <= 1'b0;
         r_bcast  <= '0;
      end else begin
         r_cnt    <= w_issue ? (r_cnt + ADDR_W'(1)) : '0;
         r_sum_en <= w_issue;
         r_bcast  <= w_issue ? w_word : '0;
      end
   end

   assign o_cnt        = r_cnt;
   assign o_cnt_last   = w_last;
   assign o_bcast_data = r_bcast;
   assign o_sum_en     = r_sum_en;

endmodule
`default_nettype wire

// File: rtl/fc_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : fc_layer_sequencer
// Brief   : Accepts an input vector, serialises it against the neurons' shared
//           weight/bias ROM, and returns the captured neuron results.
// Revision: 1.0 - initial release
// ============================================================================
module fc_layer_sequencer
   import fc_seq_pkg::*;
#(
   parameter int WORD_SIZE             = 16,
   parameter int PREVIOUS_LAYER_HEIGHT = 4,
   parameter int LAYER_HEIGHT          = 4
)(
   input  logic                                          clk_i,
   input  logic                                          reset_i,
   input  logic [PREVIOUS_LAYER_HEIGHT*WORD_SIZE-1:0]    data_i,
   input  logic                                          valid_i,
   output logic                                          ready_o,
   output logic [addr_width(PREVIOUS_LAYER_HEIGHT)-1:0]  mem_addr_o,
   output logic signed [WORD_SIZE-1:0]                   bcast_data_o,
   output logic                                          sum_en_o,
   output logic                                          add_bias_o,
   input  logic [LAYER_HEIGHT*WORD_SIZE-1:0]             neuron_data_i,
   output logic [LAYER_HEIGHT*WORD_SIZE-1:0]             layer_data_o,
   output logic                                          valid_o,
   input  logic                                          ready_i
);

   localparam int c_addr_w = addr_width(PREVIOUS_LAYER_HEIGHT);

   fc_seq_state_t                              r_state;
   fc_seq_state_t                              w_next_state;
   logic [PREVIOUS_LAYER_HEIGHT*WORD_SIZE-1:0] r_data_in;
   logic [LAYER_HEIGHT*WORD_SIZE-1:0]          r_layer_data;
   logic [c_addr_w-1:0]                        w_cnt;
   logic                                       w_cnt_last;
   logic                                       w_run;
   logic                                       w_load;
   logic                                       w_capture;
   logic [WORD_SIZE-1:0]                       w_bcast;
   logic                                       w_sum_en;

   assign w_run = (r_state == RUN);

   fc_seq_addr_pipe #(
      .WORD_SIZE             (WORD_SIZE),
      .PREVIOUS_LAYER_HEIGHT (PREVIOUS_LAYER_HEIGHT),
      .ADDR_W                (c_addr_w)
   ) u_addr_pipe (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .i_run        (w_run),
      .i_data       (r_data_in),
      .o_cnt        (w_cnt),
      .o_cnt_last   (w_cnt_last),
      .o_bcast_data (w_bcast),
      .o_sum_en     (w_sum_en)
   );

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_load       = 1'b0;
      w_capture    = 1'b0;
      ready_o      = 1'b0;
      valid_o      = 1'b0;
      add_bias_o   = 1'b0;
      case (r_state)
         IDLE: begin
            ready_o = 1'b1;
            if (valid_i) begin
               w_load       = 1'b1;
               w_next_state = RUN;
            end
         end
         RUN: begin
            if (w_cnt_last) begin
               w_next_state = BIAS;
            end
         end
         BIAS: begin
            add_bias_o   = 1'b1;
            w_next_state = CAPTURE;
         end
         // Neuron outputs are registered by now, one cycle after the bias add.
         CAPTURE: begin
            w_capture    = 1'b1;
            w_next_state = OUT;
         end
         OUT: begin
            valid_o = 1'b1;
            if (ready_i) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_data_in    <= '0;
         r_layer_data <= '0;
      end else begin
         if (w_load) begin
            r_data_in <= data_i;
         end
         if (w_capture) begin
            r_layer_data <= neuron_data_i;
         end
      end
   end

   assign mem_addr_o   = w_run ? w_cnt : '0;
   assign bcast_data_o = $signed(w_bcast);
   assign sum_en_o     = w_sum_en;
   assign layer_data_o = r_layer_data;

endmodule
`default_nettype wire

// File: tb/tb_fc_layer_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_fc_layer_sequencer
// Brief   : Self-checking bench for fc_layer_sequencer (H=4 main instance and
//           an H=1 instance for the single-word edge case).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fc_layer_sequencer;

   localparam int W = 16;
   localparam int H = 4;
   localparam int N = 2;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Main instance (H=4, N=2)
   logic [H*W-1:0]        data_i = '0;
   logic                  valid_i = 1'b0;
   logic                  ready_o;
   logic [2:0]            mem_addr;
   logic signed [W-1:0]   bcast;
   logic                  sum_en;
   logic                  add_bias;
   logic [N*W-1:0]        neuron_data = '0;
   logic [N*W-1:0]        layer_data;
   logic                  valid_o;
   logic                  ready_i = 1'b0;

   // Edge instance (H=1, N=2)
   logic [W-1:0]          d1_data = '0;
   logic                  d1_valid_i = 1'b0;
   logic                  d1_ready_o;
   logic [0:0]            d1_addr;
   logic signed [W-1:0]   d1_bcast;
   logic                  d1_sum_en;
   logic                  d1_add_bias;
   logic [N*W-1:0]        d1_neuron = '0;
   logic [N*W-1:0]        d1_layer;
   logic                  d1_valid_o;
   logic                  d1_ready_i = 1'b0;

   fc_layer_sequencer #(.WORD_SIZE(W), .PREVIOUS_LAYER_HEIGHT(H), .LAYER_HEIGHT(N)) dut (
      .clk_i(clk), .reset_i(reset_n), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
      .mem_addr_o(mem_addr), .bcast_data_o(bcast), .sum_en_o(sum_en), .add_bias_o(add_bias),
      .neuron_data_i(neuron_data), .layer_data_o(layer_data), .valid_o(valid_o), .ready_i(ready_i)
   );

   fc_layer_sequencer #(.WORD_SIZE(W), .PREVIOUS_LAYER_HEIGHT(1), .LAYER_HEIGHT(N)) dut1 (
      .clk_i(clk), .reset_i(reset_n), .data_i(d1_data), .valid_i(d1_valid_i), .ready_o(d1_ready_o),
      .mem_addr_o(d1_addr), .bcast_data_o(d1_bcast), .sum_en_o(d1_sum_en), .add_bias_o(d1_add_bias),
      .neuron_data_i(d1_neuron), .layer_data_o(d1_layer), .valid_o(d1_valid_o), .ready_i(d1_ready_i)
   );

   // Expected per-cycle outputs for cycle c after the accepting edge, from the
   // timing table: addresses in 1..H+1, words in 2..H+1, bias at H+2.
   function automatic logic [22:0] model_run(input logic [H*W-1:0] vec, input int c);
      logic [2:0]   a  = 3'd0;
      logic         s  = 1'b0;
      logic [W-1:0] b  = '0;
      logic         ab = 1'b0;
      if (c >= 1 && c <= H + 1) a = 3'(c - 1);
      if (c >= 2 && c <= H + 1) begin
         s = 1'b1;
         b = vec[(c-2)*W +: W];
      end
      ab = (c == H + 2);
      return {a, s, b, ab, 1'b0, 1'b0};
   endfunction

   task automatic run_trace(input logic [H*W-1:0] vec, input bit busy, output logic [N*W-1:0] exp_layer);
      logic [22:0] got;
      logic [22:0] exp;
      exp_layer = '0;
      for (int c = 1; c <= H + 3; c++) begin
         @(negedge clk);
         got = {mem_addr, sum_en, bcast, add_bias, valid_o, ready_o};
         exp = model_run(vec, c);
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL trace c=%0d got=%h expected=%h", c, got, exp);
         end
         neuron_data = $urandom;
         if (c == H + 3) exp_layer = neuron_data;
         ready_i = 1'($urandom);
         valid_i = busy;
         data_i  = {$urandom, $urandom};
      end
   endtask

   task automatic finish_out(input logic [N*W-1:0] exp_layer, input int hold, input bit busy);
      for (int k = 0; k <= hold; k++) begin
         @(negedge clk);
         n_cmp++;
         if (valid_o !== 1'b1 || ready_o !== 1'b0 || sum_en !== 1'b0 || layer_data !== exp_layer) begin
            n_err++;
            $display("FAIL out k=%0d valid=%b ready_o=%b sum_en=%b layer=%h expected valid=1 ready_o=0 sum_en=0 layer=%h",
                     k, valid_o, ready_o, sum_en, layer_data, exp_layer);
         end
         ready_i     = (k == hold);
         valid_i     = busy;
         neuron_data = $urandom;
      end
      @(negedge clk);
      n_cmp++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1 || layer_data !== exp_layer) begin
         n_err++;
         $display("FAIL idle_return valid=%b ready_o=%b layer=%h expected valid=0 ready_o=1 layer=%h",
                  valid_o, ready_o, layer_data, exp_layer);
      end
      ready_i = 1'b0;
      valid_i = 1'b0;
   endtask

   task automatic run_vector(input logic [H*W-1:0] vec, input int hold, input bit busy);
      logic [N*W-1:0] el;
      @(negedge clk);
      n_cmp++;
      if (ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL accept_ready ready_o=%b expected 1", ready_o);
      end
      data_i  = vec;
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = busy;
      data_i  = {$urandom, $urandom};
      run_trace(vec, busy, el);
      finish_out(el, hold, busy);
   endtask

   task automatic test_reset();
      #12;
      n_cmp++;
      if ({mem_addr, sum_en, bcast, add_bias, valid_o, ready_o, layer_data} !== {3'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 32'd0}) begin
         n_err++;
         $display("FAIL reset_main addr=%h sum_en=%b bcast=%h bias=%b valid=%b ready_o=%b layer=%h expected all 0, ready_o=1",
                  mem_addr, sum_en, bcast, add_bias, valid_o, ready_o, layer_data);
      end
      n_cmp++;
      if ({d1_addr, d1_sum_en, d1_bcast, d1_add_bias, d1_valid_o, d1_ready_o, d1_layer} !== {1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 32'd0}) begin
         n_err++;
         $display("FAIL reset_h1 addr=%h sum_en=%b bcast=%h valid=%b ready_o=%b layer=%h expected all 0, ready_o=1",
                  d1_addr, d1_sum_en, d1_bcast, d1_valid_o, d1_ready_o, d1_layer);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0 || sum_en !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset_idle ready_o=%b valid=%b sum_en=%b expected 1 0 0", ready_o, valid_o, sum_en);
      end
   endtask

   task automatic test_basic();
      run_vector({16'd4, 16'd3, 16'd2, 16'd1}, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 4; i++) begin
         run_vector({$urandom, $urandom}, int'($urandom_range(0, 3)), 1'b0);
      end
   endtask

   task automatic test_backpressure();
      run_vector({$urandom, $urandom}, 10, 1'b0);
   endtask

   task automatic test_busy_input();
      run_vector({$urandom, $urandom}, 2, 1'b1);
      run_vector({$urandom, $urandom}, 0, 1'b0);
   endtask

   task automatic test_reset_mid_run();
      bit seen;
      @(negedge clk);
      data_i  = {$urandom, $urandom};
      valid_i = 1'b1;
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if ({mem_addr, sum_en, bcast, add_bias, valid_o, ready_o, layer_data} !== {3'd0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 32'd0}) begin
         n_err++;
         $display("FAIL mid_reset addr=%h sum_en=%b bcast=%h bias=%b valid=%b ready_o=%b layer=%h expected all 0, ready_o=1",
                  mem_addr, sum_en, bcast, add_bias, valid_o, ready_o, layer_data);
      end
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (valid_o !== 1'b0 || sum_en !== 1'b0 || ready_o !== 1'b1) seen = 1'b1;
      end
      n_cmp++;
      if (seen) begin
         n_err++;
         $display("FAIL abandon_after_reset activity=%b expected 0", seen);
      end
      run_vector({$urandom, $urandom}, 1, 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [H*W-1:0] a;
      logic [H*W-1:0] b;
      logic [N*W-1:0] el;
      int t1;
      int t2;
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      t1 = -1;
      t2 = -1;
      @(negedge clk);
      data_i  = a;
      valid_i = 1'b1;
      ready_i = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (t1 >= 0) data_i = b;
         if (ready_o === 1'b1) begin
            if (t1 < 0) t1 = cyc;
            else begin
               t2 = cyc;
               break;
            end
         end
         @(negedge clk);
      end
      n_cmp++;
      if (t2 < 0) begin
         n_err++;
         $display("FAIL b2b_timeout second accept not seen within 40 cycles");
         valid_i = 1'b0;
      end else if (t2 - t1 != H + 5) begin
         n_err++;
         $display("FAIL b2b_spacing got=%0d expected=%0d", t2 - t1, H + 5);
      end
      if (t2 >= 0) begin
         @(posedge clk);
         #1;
         valid_i = 1'b0;
         run_trace(b, 1'b0, el);
         finish_out(el, 0, 1'b0);
      end
   endtask

   task automatic test_edge_h1();
      logic [W-1:0]   v;
      logic [N*W-1:0] el;
      logic [20:0]    got;
      logic [20:0]    exp;
      for (int n = 0; n < 2; n++) begin
         v  = (n == 0) ? 16'h8000 : 16'($urandom);
         el = '0;
         @(negedge clk);
         n_cmp++;
         if (d1_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL h1_ready ready_o=%b expected 1", d1_ready_o);
         end
         d1_data    = v;
         d1_valid_i = 1'b1;
         @(posedge clk);
         #1;
         d1_valid_i = 1'b0;
         d1_data    = 16'($urandom);
         for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            got = {d1_addr, d1_sum_en, d1_bcast, d1_add_bias, d1_valid_o, d1_ready_o};
            exp = {1'(c == 2), c == 2, (c == 2) ? v : 16'd0, c == 3, 1'b0, 1'b0};
            n_cmp++;
            if (got !== exp) begin
               n_err++;
               $display("FAIL h1_trace c=%0d got=%h expected=%h", c, got, exp);
            end
            d1_neuron = $urandom;
            if (c == 4) el = d1_neuron;
         end
         @(negedge clk);
         n_cmp++;
         if (d1_valid_o !== 1'b1 || d1_layer !== el) begin
            n_err++;
            $display("FAIL h1_out valid=%b layer=%h expected valid=1 layer=%h", d1_valid_o, d1_layer, el);
         end
         d1_ready_i = 1'b1;
         @(negedge clk);
         n_cmp++;
         if (d1_valid_o !== 1'b0 || d1_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL h1_idle valid=%b ready_o=%b expected 0 1", d1_valid_o, d1_ready_o);
         end
         d1_ready_i = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_backpressure();
      test_busy_input();
      test_reset_mid_run();
      test_back_to_back();
      test_edge_h1();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
